apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB4 completer (slave) with a word-addressed register memory.
- It is the DUT-side counterpart to the team's APB UVM requester agent: the driver issues transfers, this block answers them with PREADY, PRDATA and PSLVERR.
- Supports byte strobes, optional wait-state insertion, and error response on bad addresses.
- Sits behind an APB bridge as a leaf peripheral.

Parameters:
- ADDR_WIDTH, 8, PADDR width in bits (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32.
- DEPTH, 64, number of 32-bit words; must be ≤ 2^(ADDR_WIDTH-2).
- WAIT_CYCLES, 2, wait states per transfer when APB_SLV_WAIT_EN is defined; range 0..15.

Ports:
- PCLK  in  1  APB clock; all state on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, registered.

Behaviour:
- Clock is PCLK. Reset is PRESETn, asynchronous assert, active-low, synchronous deassert handled upstream.
- Reset values:
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - FSM = IDLE, wait counter = 0.
  - All memory words = 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA and PSTRB, evaluate the error condition, and go to ACCESS.
  - Otherwise stay in IDLE with PREADY=0.
- Error condition: index = PADDR[ADDR_WIDTH-1:2]. Error if index ≥ DEPTH or PADDR[1:0] ≠ 0.
- ACCESS without wait states: PREADY=1 in the first access cycle, i.e. a 2-cycle transfer.
- ACCESS with wait states: PREADY=0 for WAIT_CYCLES access cycles, then 1 (see Optional Feature).
- Completion cycle (PSEL=1, PENABLE=1, PREADY=1):
  - Write, no error: mem[index] byte lanes with PSTRB[i]=1 are updated at the end of this cycle; other lanes are kept.
  - Read, no error: PRDATA = mem[index] during this cycle.
  - Error: no memory update, PRDATA = 0, PSLVERR = 1 in this cycle only.
  - Next state is IDLE; PREADY, PSLVERR and PRDATA return to 0 the following cycle.
- Back-to-back transfers: a setup phase immediately after completion is accepted from IDLE. Throughput is 1 transfer per 2 cycles at 0 waits.
- Read-after-write to the same address returns the new data.
- PSTRB=0 on a write is a legal no-op write with PSLVERR=0.
- PSTRB on a read is ignored.
- Protocol abort: PSEL or PENABLE low while in ACCESS before completion means go to IDLE, no write, outputs 0, no PSLVERR.
- Address, data or control changes during ACCESS are ignored; latched values are used.
- Reset mid-transfer: outputs and memory are cleared immediately; any pending write is discarded.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined:
  - A 4-bit counter loads WAIT_CYCLES on entry to ACCESS and decrements each access cycle.
  - PREADY=1 when the counter is 0, giving WAIT_CYCLES+2 cycles per transfer.
  - WAIT_CYCLES=0 behaves identically to the undefined case.
- Undefined: no counter is built; PREADY=1 in the first access cycle.
- Error responses obey the same wait timing in both cases.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10:
  - PRDATA=0xDEADBEEF, PSLVERR=0.
  - Each transfer is 2 cycles (feature undefined).
- Write 0x11223344 to 0x04, then write 0xAABBCCDD with PSTRB=0x5, then read 0x04 -> PRDATA=0x11BB33DD.
- Write to 0x100 (index 64 ≥ DEPTH) and read from 0x06 (unaligned):
  - PSLVERR=1 and PRDATA=0 in the completion cycle.
  - A subsequent read of 0x00 returns its prior value unchanged.
- APB_SLV_WAIT_EN with WAIT_CYCLES=2: read 0x08 -> PREADY low 2 access cycles then high; transfer is 4 cycles; PRDATA is valid only in the PREADY cycle.
- Back-to-back write 0x20 followed by read 0x20 with no idle cycle -> read returns the written value; no cycle is lost between transfers.
- Assert PRESETn=0 during the access phase of a write to 0x0C:
  - PREADY and PRDATA drop to 0 immediately.
  - After release, a read of 0x0C returns 0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//   APB4 completer backed by a small word-addressed register memory. Each
//   transfer is latched in the setup phase and answered in the access phase
//   with registered PREADY / PRDATA / PSLVERR. Byte strobes select which lanes
//   a write updates. Misaligned addresses and word indices at or beyond DEPTH
//   return PSLVERR and leave memory untouched.
//
//   Build option:
//     APB_SLV_WAIT_EN  when defined, each transfer inserts WAIT_CYCLES wait
//                      states before PREADY is raised. Error responses use the
//                      same timing. When undefined, PREADY is raised in the
//                      first access cycle and no wait counter exists.
//
//   Ports:
//     PCLK     in   clock, all state on the rising edge
//     PRESETn  in   asynchronous active-low reset (clears memory as well)
//     PSEL     in   completer select
//     PENABLE  in   access-phase indicator
//     PWRITE   in   1 = write, 0 = read
//     PADDR    in   byte address [ADDR_WIDTH]
//     PWDATA   in   write data [DATA_WIDTH]
//     PSTRB    in   write byte strobes [DATA_WIDTH/8], ignored on reads
//     PRDATA   out  read data, registered, non-zero only in the ready cycle
//     PREADY   out  transfer complete, registered
//     PSLVERR  out  error response, registered, only in the ready cycle
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  // Reject parameter sets the datapath cannot honour.
  if (DATA_WIDTH != 32 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
      DEPTH < 2 || DEPTH > (1 << (ADDR_WIDTH - 2))) begin : g_param_check
    $error("apb_slave_mem: unsupported parameter combination");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           strb_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    pready_q;
  logic                    pslverr_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    setup_phase;
  logic                    access_ok;
  logic                    addr_err;
  logic [IDX_W-1:0]        setup_idx;
  logic                    mem_we;

  assign setup_phase = PSEL & ~PENABLE;
  assign access_ok   = PSEL & PENABLE;

  // The full word index is compared against DEPTH before it is truncated to
  // the storage index, so out-of-range addresses can never alias a real word.
  assign addr_err  = (32'(PADDR[ADDR_WIDTH-1:2]) >= 32'(DEPTH)) || (PADDR[1:0] != 2'b00);
  assign setup_idx = PADDR[IDX_W+1:2];

  // pready_q is only ever high in ACCESS, so this is exactly the completion cycle.
  assign mem_we = (state_q == ACCESS) & access_ok & pready_q & write_q & ~err_q;

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      // Responses last exactly one cycle; every other cycle they read as zero.
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (setup_phase) begin
            state_q <= ACCESS;
            idx_q   <= setup_idx;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= addr_err;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              pready_q  <= 1'b1;
              pslverr_q <= addr_err;
              prdata_q  <= (!addr_err && !PWRITE) ? mem_q[setup_idx] : '0;
            end
`else
            pready_q  <= 1'b1;
            pslverr_q <= addr_err;
            prdata_q  <= (!addr_err && !PWRITE) ? mem_q[setup_idx] : '0;
`endif
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            // Requester dropped the transfer early: abandon it silently.
            state_q <= IDLE;
          end
`ifdef APB_SLV_WAIT_EN
          else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
            // Memory cannot change while this transfer is pending, so the
            // read can be taken from the latched index on the last wait cycle.
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= (!err_q && !write_q) ? mem_q[idx_q] : '0;
            end
          end
`endif
          else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//   Directed bench for apb_slave_mem. A table of transfers is issued
//   back-to-back and each response is compared against hand-computed values;
//   short hand-written sequences cover reset state, protocol abort and reset
//   during an access phase. Inputs are driven and outputs sampled on the
//   falling edge of PCLK.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int AW = 9;   // wide enough to express index 64 (address 0x100)
  localparam int DW = 32;
`ifdef APB_SLV_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif
  localparam int XFER_CYC = WAITS + 2;
  localparam int MAX_CYC  = 40;

  logic          PCLK;
  logic          PRESETn;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (64),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Called on a falling edge. Returns on the falling edge after completion,
  // with PSEL/PENABLE still high so a following call is truly back-to-back.
  // Address/data/control are scrambled during the access phase; the
  // completer must keep using what it latched in the setup phase.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int cyc, output bit early_bad);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
    cyc = 1;
    early_bad = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1; cyc = 2;
    PADDR = addr ^ 9'h1FF; PWDATA = ~wd; PSTRB = ~st; PWRITE = ~wr;
    while (!PREADY && cyc < MAX_CYC) begin
      if (PRDATA != 32'h0 || PSLVERR) early_bad = 1'b1;
      @(negedge PCLK);
      cyc++;
    end
    rd = PRDATA;
    er = PSLVERR;
    @(negedge PCLK);
  endtask

  task automatic go_idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    bit          eb;

    vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 9'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h004, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 9'h004, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 9'h004, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 9'h000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 9'h100, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 9'h006, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 9'h000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 9'h020, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 9'h020, 32'h0,        4'hF, 32'h0BADC0DE, 1'b0};
    vecs[11] = '{1'b1, 9'h008, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 9'h008, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0};
    vecs[13] = '{1'b1, 9'h1FC, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 9'h0FC, 32'h87654321, 4'hC, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 9'h0FC, 32'h0,        4'h0, 32'h87650000, 1'b0};
    vecs[16] = '{1'b1, 9'h004, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 9'h004, 32'h0,        4'h3, 32'h11BB33DD, 1'b0};
    vecs[18] = '{1'b0, 9'h101, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[19] = '{1'b0, 9'h0FD, 32'h0,        4'hF, 32'h0,        1'b1};

    // ---- reset state ----
    go_idle();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("reset_pready",  {31'h0, PREADY},  32'h0);
    chk("reset_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk("reset_prdata",  PRDATA,           32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("idle_pready", {31'h0, PREADY}, 32'h0);

    // ---- table: all transfers issued back-to-back ----
    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, cyc, eb);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(XFER_CYC));
      chk($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      if (!vecs[i].wr || vecs[i].exp_err)
        chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_early_resp", i), {31'h0, eb}, 32'h0);
      $display("xfer %0d %s addr=0x%03h wdata=0x%08h strb=%h -> prdata=0x%08h pslverr=%0b cycles=%0d",
               i, vecs[i].wr ? "W" : "R", vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, cyc);
    end
    // Outputs must fall back to zero the cycle after completion.
    chk("post_pready",  {31'h0, PREADY},  32'h0);
    chk("post_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk("post_prdata",  PRDATA,           32'h0);
    go_idle();
    @(negedge PCLK);

    // ---- protocol abort: setup, then PSEL dropped before completion ----
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h014; PWDATA = 32'h77777777; PSTRB = 4'hF;
    @(negedge PCLK);
    go_idle();
    @(negedge PCLK);
    chk("abort_pready",  {31'h0, PREADY},  32'h0);
    chk("abort_pslverr", {31'h0, PSLVERR}, 32'h0);
    xfer(1'b0, 9'h014, 32'h0, 4'hF, rd, er, cyc, eb);
    chk("abort_no_write", rd, 32'h0);
    $display("abort then R addr=0x014 -> prdata=0x%08h pslverr=%0b cycles=%0d", rd, er, cyc);
    go_idle();
    @(negedge PCLK);

    // ---- reset during the access phase of a write to 0x0C ----
    xfer(1'b1, 9'h00C, 32'h13572468, 4'hF, rd, er, cyc, eb);
    xfer(1'b0, 9'h00C, 32'h0, 4'hF, rd, er, cyc, eb);
    chk("pre_reset_read", rd, 32'h13572468);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h00C; PWDATA = 32'h99999999; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    PRESETn = 1'b0;
    #1;
    chk("midrst_pready", {31'h0, PREADY}, 32'h0);
    chk("midrst_prdata", PRDATA,          32'h0);
    @(negedge PCLK);
    go_idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    xfer(1'b0, 9'h00C, 32'h0, 4'hF, rd, er, cyc, eb);
    chk("midrst_read_0c", rd, 32'h0);
    $display("reset mid-write, then R addr=0x00C -> prdata=0x%08h pslverr=%0b", rd, er);
    xfer(1'b0, 9'h010, 32'h0, 4'hF, rd, er, cyc, eb);
    chk("midrst_read_10", rd, 32'h0);
    $display("after reset R addr=0x010 -> prdata=0x%08h pslverr=%0b", rd, er);
    go_idle();
    @(negedge PCLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
